// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: ALU operation codes and operand forward selects.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU: add/sub/and/or/signed slt, wrap-around, with zero flag.
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch resolve,
// branch target and the EX/MEM pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    input  logic                 ResultSrcE,
    input  logic                 BranchE,
    input  logic                 ALUSrcE,
    input  logic [2:0]           ALUControlE,
    input  logic [XLEN-1:0]      RD1_E,
    input  logic [XLEN-1:0]      RD2_E,
    input  logic [XLEN-1:0]      Imm_Ext_E,
    input  logic [REGADDR_W-1:0] RD_E,
    input  logic [XLEN-1:0]      PCE,
    input  logic [XLEN-1:0]      PCPlus4E,
    input  logic [XLEN-1:0]      ResultW,
    input  logic [1:0]           ForwardAE,
    input  logic [1:0]           ForwardBE,
    output logic                 PCSrcE,
    output logic [XLEN-1:0]      PCTargetE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 ResultSrcM,
    output logic [REGADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]      PCPlus4M,
    output logic [XLEN-1:0]      WriteDataM,
    output logic [XLEN-1:0]      ALU_ResultM
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // The M forward source is the registered ALU result, so no combinational loop exists.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_M:   src_a = ALU_ResultM;
            FWD_W:   src_a = ResultW;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        src_b_fwd = RD2_E;
        case (ForwardBE)
            FWD_M:   src_b_fwd = ALU_ResultM;
            FWD_W:   src_b_fwd = ResultW;
            default: src_b_fwd = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .A         (src_a),
        .B         (src_b),
        .ALUControl(ALUControlE),
        .Result    (alu_result),
        .Zero      (zero)
    );

    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Store data is the forwarded rs2 value, never the immediate.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= src_b_fwd;
            ALU_ResultM <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed literal cases plus randomized
// stimulus compared each cycle against a behavioural model of the EX stage.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int checks   = 0;
    int failures = 0;

    // Model state for the MEM-stage register contents.
    logic        m_rw, m_mw, m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_pc4, m_wd, m_alu;

    always #5 clk = ~clk;

    execute_cycle #(
        .XLEN     (32),
        .REGADDR_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .BranchE    (BranchE),
        .ALUSrcE    (ALUSrcE),
        .ALUControlE(ALUControlE),
        .RD1_E      (RD1_E),
        .RD2_E      (RD2_E),
        .Imm_Ext_E  (Imm_Ext_E),
        .RD_E       (RD_E),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E),
        .ResultW    (ResultW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .PCPlus4M   (PCPlus4M),
        .WriteDataM (WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd2) return m_alu;
        if (sel == 2'd1) return ResultW;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic tick();
        logic [31:0] a, bf, b, r;
        a  = pick(ForwardAE, RD1_E);
        bf = pick(ForwardBE, RD2_E);
        b  = ALUSrcE ? Imm_Ext_E : bf;
        r  = alu_ref(a, b, ALUControlE);
        #1;
        chk("PCSrcE", 32'(PCSrcE), 32'(BranchE && (r == 32'd0)));
        chk("PCTargetE", PCTargetE, PCE + Imm_Ext_E);
        @(posedge clk);
        if (rst) begin
            m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_pc4 = 0; m_wd = 0; m_alu = 0;
        end else begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RD_E;
            m_pc4 = PCPlus4E; m_wd = bf; m_alu = r;
        end
        #1;
        chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
        chk("MemWriteM", 32'(MemWriteM), 32'(m_mw));
        chk("ResultSrcM", 32'(ResultSrcM), 32'(m_rs));
        chk("RD_M", 32'(RD_M), 32'(m_rd));
        chk("PCPlus4M", PCPlus4M, m_pc4);
        chk("WriteDataM", WriteDataM, m_wd);
        chk("ALU_ResultM", ALU_ResultM, m_alu);
        @(negedge clk);
    endtask

    task automatic defaults();
        rst = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
        ALUControlE = 3'd0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0; PCE = 0;
        PCPlus4E = 0; ResultW = 0; ForwardAE = 0; ForwardBE = 0;
    endtask

    initial begin
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_pc4 = 0; m_wd = 0; m_alu = 0;
        defaults();
        rst = 1;
        @(negedge clk);

        // Reset holds M outputs at zero despite active EX controls.
        RegWriteE = 1; MemWriteE = 1; RD_E = 5'd7;
        tick();
        tick();
        chk("lit_rst_regwrite", 32'(RegWriteM), 32'd0);
        chk("lit_rst_rd", 32'(RD_M), 32'd0);
        rst = 0;
        tick();
        chk("lit_post_rst_regwrite", 32'(RegWriteM), 32'd1);
        chk("lit_post_rst_rd", 32'(RD_M), 32'd7);

        // Back-to-back dependency via M forward.
        defaults();
        RD1_E = 5; RD2_E = 3;
        tick();
        chk("lit_add", ALU_ResultM, 32'd8);
        ForwardAE = 2'b10; RD1_E = 0; RD2_E = 1;
        tick();
        chk("lit_fwd_m", ALU_ResultM, 32'd9);

        // W forward on B: immediate feeds ALU, forwarded value is the store data.
        defaults();
        ForwardBE = 2'b01; ResultW = 32'h1234; ALUSrcE = 1; Imm_Ext_E = 4;
        RD1_E = 32'h100; MemWriteE = 1;
        tick();
        chk("lit_imm_add", ALU_ResultM, 32'h104);
        chk("lit_store_data", WriteDataM, 32'h1234);

        defaults();
        ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
        tick();
        chk("lit_slt_neg", ALU_ResultM, 32'd1);
        RD1_E = 1; RD2_E = 32'hFFFF_FFFF;
        tick();
        chk("lit_slt_swap", ALU_ResultM, 32'd0);

        defaults();
        BranchE = 1; ALUControlE = 3'b001; RD1_E = 42; RD2_E = 42; PCE = 32'h40;
        Imm_Ext_E = 32'hFFFF_FFF8;
        tick();
        chk("lit_beq_taken", 32'(PCSrcE), 32'd1);
        chk("lit_beq_target", PCTargetE, 32'h38);
        RD2_E = 41;
        tick();
        chk("lit_beq_not_taken", 32'(PCSrcE), 32'd0);

        defaults();
        RD1_E = 32'hFFFF_FFFF; RD2_E = 2;
        tick();
        chk("lit_wrap", ALU_ResultM, 32'd1);
        ForwardAE = 2'b11; RD1_E = 6; RD2_E = 1;
        tick();
        chk("lit_fwd_illegal", ALU_ResultM, 32'd7);

        // Reset mid-operation kills the in-flight write and store.
        RegWriteE = 1; MemWriteE = 1; rst = 1;
        tick();
        chk("lit_midrst_regwrite", 32'(RegWriteM), 32'd0);
        chk("lit_midrst_memwrite", 32'(MemWriteM), 32'd0);
        rst = 0;

        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 19) == 0);
            RegWriteE   = 1'($urandom);
            MemWriteE   = 1'($urandom);
            ResultSrcE  = 1'($urandom);
            BranchE     = 1'($urandom);
            ALUSrcE     = ($urandom_range(0, 3) == 0);
            ALUControlE = 3'($urandom);
            RD1_E       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            RD2_E       = ($urandom_range(0, 2) == 0) ? RD1_E : $urandom;
            Imm_Ext_E   = $urandom;
            RD_E        = 5'($urandom);
            PCE         = $urandom;
            PCPlus4E    = PCE + 4;
            ResultW     = $urandom;
            ForwardAE   = 2'($urandom);
            ForwardBE   = 2'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute (EX) stage of the 5-stage pipelined RV32I core.
- Sits between the ID/EX register outputs and the MEM stage.
- Consumes the forwarding selects from the hazard unit, resolves operands, runs the ALU and branch compare, and computes the branch target.
- Owns the EX/MEM pipeline register.
- Registered ALU result is fed back internally as the MEM-stage forward source; M-stage destination/write-enable are exported to the hazard unit.

Parameters:
- XLEN, 32, datapath width
- REGADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- RegWriteE  in  1  EX-stage register write enable
- MemWriteE  in  1  EX-stage store enable
- ResultSrcE  in  1  writeback select (0 = ALU, 1 = memory)
- BranchE  in  1  instruction is BEQ
- ALUSrcE  in  1  ALU B source (0 = register, 1 = immediate)
- ALUControlE  in  3  ALU operation
- RD1_E, RD2_E  in  XLEN  register file read data
- Imm_Ext_E  in  XLEN  sign-extended immediate
- RD_E  in  REGADDR_W  destination register
- PCE, PCPlus4E  in  XLEN  instruction PC and PC+4
- ResultW  in  XLEN  writeback-stage result (W forward source)
- ForwardAE, ForwardBE  in  2  operand forward selects from the hazard unit
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  XLEN  PCE + Imm_Ext_E (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered control
- RD_M  out  REGADDR_W  registered destination
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN  registered data

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Operand A mux:
  - ForwardAE 00 → RD1_E; 10 → ALU_ResultM; 01 → ResultW.
  - 11 is illegal and behaves as 00.
- Operand B mux (pre-ALUSrc): same encoding on RD2_E using ForwardBE, giving SrcB_fwd.
- SrcB = ALUSrcE ? Imm_Ext_E : SrcB_fwd.
- ALU, combinational, XLEN wide, wrap-around arithmetic, no overflow flag:
  - 000 add; 001 sub; 010 and; 011 or.
  - 101 slt: signed compare; result is 1 or 0, zero-extended.
  - All other codes → 0.
- ZeroE = (ALU result == 0). PCSrcE = BranchE & ZeroE. BEQ is issued with ALUControlE = 001.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN.
- EX/MEM register, 1-cycle latency, updates every cycle (no stall or flush inputs):
  - RegWriteM ← RegWriteE; MemWriteM ← MemWriteE; ResultSrcM ← ResultSrcE.
  - RD_M ← RD_E; PCPlus4M ← PCPlus4E.
  - WriteDataM ← SrcB_fwd, i.e. the forwarded store data, never the immediate.
  - ALU_ResultM ← ALU result.
- Reset:
  - When rst is high at posedge, every registered output is cleared to 0: RegWriteM=0, MemWriteM=0, ResultSrcM=0, RD_M=0, PCPlus4M=0, WriteDataM=0, ALU_ResultM=0.
  - Reset mid-operation discards the in-flight EX instruction; no write or store escapes in the following MEM cycle.
- Combinational outputs (PCSrcE, PCTargetE) are not gated by rst. The upstream fetch stage owns reset of the PC.
- Forward feedback path: ALU_ResultM is fed back from the register output, so there is no combinational loop.
- Back-to-back dependent ALU ops resolve with zero bubbles.
- Load-use stalls are out of scope for this block.

Decomposition:
- Shared package riscv_pkg:
  - ALU op localparams: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - Forward select localparams: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module: alu (inputs A, B, ALUControl; outputs Result, Zero). Purely combinational, reusable.
- Forward muxes and the EX/MEM register stay in execute_cycle.

Test Plan:
- Reset: hold rst=1 two cycles with RegWriteE=1, MemWriteE=1, RD_E=7 → all M outputs 0. Release, then next posedge → RegWriteM=1, RD_M=7.
- M forward: cycle 1 add, RD1_E=5, RD2_E=3 → ALU_ResultM=8. Cycle 2 ForwardAE=10, RD1_E=0, RD2_E=1 with add → ALU_ResultM=9.
- W forward and store data: ForwardBE=01, ResultW=0x1234, ALUSrcE=1, Imm_Ext_E=4, RD1_E=0x100, MemWriteE=1 → ALU_ResultM=0x104, WriteDataM=0x1234.
- Signed slt: RD1_E=0xFFFFFFFF, RD2_E=1, ALUControlE=101 → ALU_ResultM=1. Operands swapped → 0.
- Branch: BranchE=1, sub, RD1_E=RD2_E=42, PCE=0x40, Imm_Ext_E=0xFFFFFFF8 → PCSrcE=1, PCTargetE=0x38. With RD2_E=41 → PCSrcE=0.
- Wrap and illegal select: add 0xFFFFFFFF+2 → ALU_ResultM=1. ForwardAE=11 with RD1_E=6, RD2_E=1, add → ALU_ResultM=7 (behaves as RF select).
